// File: rtl/uart_rx.sv
// 8-bit asynchronous serial receiver: 1 start, 8 data (LSB first), 1 stop, mid-bit sampling.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data and stop bits.
module uart_rx #(
  parameter int unsigned CLOCK_DIV = 104
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       framing_error,
  output logic       parity_error,
  output logic       busy
);

  localparam logic [15:0] HalfCnt = 16'(CLOCK_DIV / 2 - 1);
  localparam logic [15:0] FullCnt = 16'(CLOCK_DIV - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_s_q, rx_prev_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        start_edge;

`ifdef UART_RX_PARITY_EN
  logic        par_bit_q, par_bit_d;
  logic        perr_q, perr_d;
  logic        parity_ok;

  assign parity_ok = ~(^shift_q ^ par_bit_q);
`endif

  assign start_edge = rx_prev_q & ~rx_s_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d = par_bit_q;
    perr_d    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = 16'd0;
        if (start_edge) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfCnt) begin
          cnt_d = 16'd0;
          // A start bit that is high again at mid-bit was a glitch.
          if (!rx_s_q) begin
            state_d   = StData;
            bit_idx_d = 3'd0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (cnt_q == FullCnt) begin
          cnt_d   = 16'd0;
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StParity: begin
`ifdef UART_RX_PARITY_EN
        if (cnt_q == FullCnt) begin
          cnt_d     = 16'd0;
          par_bit_d = rx_s_q;
          state_d   = StStop;
        end
`else
        cnt_d   = 16'd0;
        state_d = StIdle;
`endif
      end
      StStop: begin
        if (cnt_q == FullCnt) begin
          cnt_d   = 16'd0;
          state_d = StIdle;
          // Framing error wins over parity error.
          if (!rx_s_q) begin
            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (!parity_ok) begin
            perr_d = 1'b1;
`endif
          end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end
      end
      default: begin
        cnt_d   = 16'd0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      par_bit_q <= par_bit_d;
      perr_q    <= perr_d;
    end
  end

  assign parity_error = perr_q;
`else
  assign parity_error = 1'b0;
`endif

  assign data_out      = data_q;
  assign data_valid    = valid_q;
  assign framing_error = ferr_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: bit-accurate line driver plus a scoreboard of expected bytes.
module tb_uart_rx;

  localparam int unsigned Div = 104;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       framing_error;
  logic       parity_error;
  logic       busy;

  uart_rx #(.CLOCK_DIV(Div)) dut (
    .clock         (clock),
    .reset         (reset),
    .rx            (rx),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .framing_error (framing_error),
    .parity_error  (parity_error),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         valid_cnt = 0;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  int         valid_cyc = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;

  always @(posedge clock) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every data_valid strobe.
  always @(negedge clock) begin
    if (data_valid) begin
      valid_cnt++;
      valid_cyc = cyc;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_byte: data_out=%02h, no byte expected", data_out);
      end else begin
        exp_byte = exp_q.pop_front();
        if (data_out !== exp_byte) begin
          miscompares++;
          $display("FAIL scoreboard_byte: data_out=%02h expected=%02h", data_out, exp_byte);
        end
      end
      if (prev_valid) begin
        miscompares++;
        $display("FAIL valid_width: data_valid high %0d consecutive cycles, expected 1", 2);
      end
    end
    if (framing_error) ferr_cnt++;
    if (parity_error) perr_cnt++;
    prev_valid = data_valid;
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (Div) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`endif
    drive_bit(stop);
  endtask

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clock);
    vectors++;
    if ({data_out, data_valid, framing_error, parity_error, busy} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_state: got %03h expected 000",
               {data_out, data_valid, framing_error, parity_error, busy});
    end
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (10) @(posedge clock);
    #1;
  endtask

  task automatic test_basic();
    int start_cyc, lows, v0, f0, lat;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    lows = 0;
    exp_q.push_back(8'hA5);
    start_cyc = cyc;
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        #2;
        repeat (5) @(negedge clock);
        repeat (980) begin
          @(negedge clock);
          if (!busy) lows++;
        end
      end
    join
    repeat (5) @(posedge clock);
    #1;
    vectors++;
    if (data_out !== 8'hA5) begin
      miscompares++;
      $display("FAIL basic_data: data_out=%02h expected=a5", data_out);
    end
    vectors++;
    if (valid_cnt - v0 != 1) begin
      miscompares++;
      $display("FAIL basic_valid_count: got %0d expected 1", valid_cnt - v0);
    end
    vectors++;
    if (ferr_cnt != f0) begin
      miscompares++;
      $display("FAIL basic_framing: got %0d pulses expected 0", ferr_cnt - f0);
    end
    vectors++;
    if (lows != 0) begin
      miscompares++;
      $display("FAIL basic_busy: busy low %0d cycles mid-frame, expected 0", lows);
    end
    lat = valid_cyc - start_cyc;
`ifdef UART_RX_PARITY_EN
    lat = lat - Div;
`endif
    vectors++;
    if (lat < 988 || lat > 992) begin
      miscompares++;
      $display("FAIL basic_latency: %0d clocks expected 988..992", lat);
    end
  endtask

  task automatic test_glitch(input logic [7:0] last_good);
    int v0, f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    rx = 1'b0;
    repeat (10) @(negedge clock);
    check("glitch_busy_rise", int'(busy), 1);
    repeat (10) @(posedge clock);
    #1 rx = 1'b1;
    repeat (40) @(posedge clock);
    @(negedge clock);
    check("glitch_busy_fall", int'(busy), 0);
    check("glitch_pulses", (valid_cnt - v0) + (ferr_cnt - f0), 0);
    check("glitch_data", int'(data_out), int'(last_good));
    repeat (20) @(posedge clock);
    #1;
  endtask

  task automatic test_framing(input logic [7:0] last_good);
    int v0, f0, highs;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    highs = 0;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (2000) begin
      @(negedge clock);
      if (busy) highs++;
    end
    check("framing_pulse", ferr_cnt - f0, 1);
    check("framing_no_valid", valid_cnt - v0, 0);
    check("framing_no_retrigger", highs, 0);
    check("framing_data_held", int'(data_out), int'(last_good));
    @(posedge clock);
    #1 rx = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0);
    repeat (5) @(posedge clock);
    #1;
    check("framing_recover_data", int'(data_out), 32'h81);
  endtask

  task automatic test_back_to_back();
    int v0, f0, p0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    p0 = perr_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h3C);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    repeat (20) @(posedge clock);
    #1;
    check("b2b_valid_count", valid_cnt - v0, 3);
    check("b2b_errors", (ferr_cnt - f0) + (perr_cnt - p0), 0);
    check("b2b_last_data", int'(data_out), 32'h3C);
  endtask

  task automatic test_reset_mid_frame();
    int v0, f0;
    logic [7:0] b;
    b = 8'h55;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx = b[4];
    repeat (50) @(posedge clock);
    #1 reset = 1'b1;
    rx = 1'b1;
    @(negedge clock);
    check("abort_busy", int'(busy), 0);
    check("abort_data", int'(data_out), 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (Div * 6) @(posedge clock);
    #1;
    check("abort_no_pulse", (valid_cnt - v0) + (ferr_cnt - f0), 0);
    check("abort_data_after", int'(data_out), 0);
    exp_q.push_back(8'h66);
    send_frame(8'h66, 1'b1, 1'b0);
    repeat (5) @(posedge clock);
    #1;
    check("abort_next_frame", int'(data_out), 32'h66);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int v0, p0;
    v0 = valid_cnt;
    p0 = perr_cnt;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (5) @(posedge clock);
    #1;
    check("parity_good_data", int'(data_out), 32'h07);
    check("parity_good_valid", valid_cnt - v0, 1);
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (5) @(posedge clock);
    #1;
    check("parity_bad_pulse", perr_cnt - p0, 1);
    check("parity_bad_no_valid", valid_cnt - v0, 1);
    check("parity_bad_data", int'(data_out), 32'h07);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch(8'hA5);
    test_framing(8'hA5);
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`else
    check("parity_tied_low", perr_cnt, 0);
`endif
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
